// File: rtl/adc_serial_rx.sv
// adc_serial_rx: serial-ADC front end that generates CS/SCLK, captures NCH data lines per frame
// and emits offset-removed signed samples. Define ADC_AVG_EN to average 2^AVG_LOG2 frames per output.
module adc_serial_rx #(
  parameter int NCH        = 2,
  parameter int FRAME_BITS = 16,
  parameter int DATA_W     = 12,
  parameter int OUT_W      = 16,
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 512,
  parameter int QUIET_CYC  = 2,
  parameter int AVG_LOG2   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NCH-1:0]       sdata,
  output logic                 cs,
  output logic                 sclk,
  output logic [NCH*OUT_W-1:0] sample,
  output logic                 valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int TMR_W      = $clog2(SAMPLE_DIV + 1);
  localparam int HALF_W     = $clog2(CLK_DIV + 1);
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);
  localparam int QUIET_LEN  = QUIET_CYC * CLK_DIV;
  localparam int QUIET_LAST = (QUIET_LEN > 0) ? QUIET_LEN - 1 : 0;
  localparam int Q_W        = $clog2(QUIET_LAST + 2);
  localparam int AVG_FRAMES = 1 << AVG_LOG2;
  localparam logic [DATA_W-1:0] MID = DATA_W'(1) << (DATA_W - 1);

  typedef enum logic [1:0] {IDLE, CONV, QUIET} state_t;

  state_t            state, state_next;
  logic [TMR_W-1:0]  tmr;
  logic [HALF_W-1:0] hcnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [Q_W-1:0]    qcnt;
  logic              tick, frame_done, quiet_done, block_done;
  logic [DATA_W-1:0] shreg [NCH];
  logic [OUT_W-1:0]  conv [NCH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 tmr <= '0;
    else if (!en)                             tmr <= '0;
    else if (tmr == TMR_W'(SAMPLE_DIV - 1))   tmr <= '0;
    else                                      tmr <= tmr + TMR_W'(1);
  end

  assign tick       = en && (tmr == TMR_W'(SAMPLE_DIV - 1));
  assign frame_done = (state == CONV) && (bit_cnt == BIT_W'(FRAME_BITS));
  assign quiet_done = (state == QUIET) && (qcnt == Q_W'(QUIET_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick)       state_next = CONV;
      CONV:    if (frame_done) state_next = QUIET;
      QUIET:   if (quiet_done) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_comb begin
    cs   = (state != CONV);
    busy = (state != IDLE);
  end

  // Capture happens on the same edge that raises sclk, so data is sampled mid-bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt    <= '0;
      bit_cnt <= '0;
      qcnt    <= '0;
      sclk    <= 1'b1;
      for (int i = 0; i < NCH; i++) shreg[i] <= '0;
    end else begin
      case (state)
        CONV: begin
          if (frame_done) begin
            hcnt    <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b1;
          end else if (hcnt == HALF_W'(CLK_DIV - 1)) begin
            hcnt <= '0;
            sclk <= ~sclk;
            if (!sclk) begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              for (int i = 0; i < NCH; i++) shreg[i] <= DATA_W'({shreg[i], sdata[i]});
            end
          end else begin
            hcnt <= hcnt + HALF_W'(1);
          end
        end
        QUIET: begin
          qcnt <= quiet_done ? '0 : qcnt + Q_W'(1);
        end
        default: begin
          hcnt    <= '0;
          bit_cnt <= '0;
          qcnt    <= '0;
          sclk    <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               overrun <= 1'b0;
    else if (!en)           overrun <= 1'b0;
    else if (tick && busy)  overrun <= 1'b1;
  end

`ifdef ADC_AVG_EN
  localparam int FC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic [FC_W-1:0] fcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            fcnt <= '0;
    else if (!en)        fcnt <= '0;
    else if (frame_done) fcnt <= block_done ? '0 : fcnt + FC_W'(1);
  end

  assign block_done = (fcnt == FC_W'(AVG_FRAMES - 1));
`else
  assign block_done = (AVG_FRAMES > 0);
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DATA_W-1:0] s_off, s_sel;

    assign s_off = shreg[i] - MID;

`ifdef ADC_AVG_EN
    logic signed [ACC_W-1:0] acc, acc_sum;

    assign acc_sum = acc + ACC_W'($signed(s_off));
    assign s_sel   = acc_sum[AVG_LOG2 +: DATA_W];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)            acc <= '0;
      else if (!en)        acc <= '0;
      else if (frame_done) acc <= block_done ? '0 : acc_sum;
    end
`else
    assign s_sel = s_off;
`endif

    if (OUT_W >= DATA_W) begin : g_ext
      assign conv[i] = OUT_W'($signed(s_sel));
    end else begin : g_trunc
      assign conv[i] = s_sel[DATA_W-1 -: OUT_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= frame_done && block_done;
      if (frame_done && block_done)
        for (int i = 0; i < NCH; i++) sample[i*OUT_W +: OUT_W] <= conv[i];
    end
  end

endmodule
